// File: rtl/demux1to4_32bit_buf.sv
// Buffered 1-to-4 demux: steers or broadcasts one producer word
// into four held channels, each released by its consumer's ack.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_data/in_sel        producer word and destination channel
//   in_bcast              deliver to all four channels at once
//   in_valid/in_ready     producer handshake (ready is combinational)
//   out0..out3            channel holding registers
//   out_valid/out_ack     per-channel hold flag and consumer take
//   busy                  any channel holds a word
module demux1to4_32bit_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic             busy
);

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [3:0]       free;
  logic [3:0]       target;
  logic [3:0]       load;
  logic             accept;

  // a channel being acked this cycle can be refilled at the same edge
  assign free = ~valid_q | out_ack;

  always_comb begin
    target = 4'b0000;
    if (in_bcast) begin
      target = 4'b1111;
    end else begin
      unique case (in_sel)
        2'd0: target = 4'b0001;
        2'd1: target = 4'b0010;
        2'd2: target = 4'b0100;
        2'd3: target = 4'b1000;
        default: target = 4'b0000;
      endcase
    end
  end

  // broadcast needs every channel free: all or nothing
  assign in_ready = in_bcast ? (&free) : (|(free & target));
  assign accept   = in_valid & in_ready;
  assign load     = accept ? target : 4'b0000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= load | (valid_q & ~out_ack);
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k] <= in_data;
        end
      end
    end
  end

  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out_valid = valid_q;
  assign busy      = |valid_q;

endmodule

// File: tb/tb_demux1to4_32bit_buf.sv
// Bench for demux1to4_32bit_buf: scoreboarded channel words
// checked on consumer ack, plus reset and handshake scenarios.
module tb_demux1to4_32bit_buf;

  logic        clk;
  logic        reset_n;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0, out1, out2, out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ack;
  logic        busy;

  int vectors;
  int miscompares;

  logic [31:0] sbq [4][$];
  logic [3:0]  mval;
  logic [31:0] last [4];

  demux1to4_32bit_buf #(.WIDTH(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_bcast(in_bcast),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out0(out0),
    .out1(out1),
    .out2(out2),
    .out3(out3),
    .out_valid(out_valid),
    .out_ack(out_ack),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outk(input int k);
    case (k)
      0: return out0;
      1: return out1;
      2: return out2;
      default: return out3;
    endcase
  endfunction

  function automatic logic [3:0] m_target();
    logic [3:0] t;
    if (in_bcast) t = 4'b1111;
    else t = 4'b0001 << in_sel;
    return t;
  endfunction

  function automatic logic m_ready();
    logic [3:0] f;
    f = ~mval | out_ack;
    if (in_bcast) return &f;
    return |(f & m_target());
  endfunction

  function automatic logic [31:0] pop_exp(input int k);
    if (sbq[k].size() == 0) return 32'hDEAD_BEEF;
    return sbq[k].pop_front();
  endfunction

  task automatic set_in(input logic [31:0] d, input logic [1:0] s,
                        input logic b, input logic v,
                        input logic [3:0] a);
    in_data  = d;
    in_sel   = s;
    in_bcast = b;
    in_valid = v;
    out_ack  = a;
    #1;
  endtask

  // advance one cycle, updating the bench model and scoreboard
  task automatic tick();
    logic [3:0] tg;
    logic       acc;
    tg  = m_target();
    acc = in_valid & m_ready();
    if (reset_n) begin
      for (int k = 0; k < 4; k++) begin
        if (acc && tg[k]) begin
          sbq[k].push_back(in_data);
          last[k] = in_data;
        end
      end
      mval = (acc ? tg : 4'b0000) | (mval & ~out_ack);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    mval = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      sbq[k].delete();
      last[k] = 32'h0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(32'h0, 2'd0, 1'b0, 1'b0, 4'b0000);
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 4'b0000 || busy !== 1'b0 || out2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b busy=%b out2=%h want 0000/0/0",
               out_valid, busy, out2);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_unicast();
    logic [31:0] e;
    set_in(32'h2, 2'd2, 1'b0, 1'b1, 4'b0000);
    vectors++;
    if (in_ready !== m_ready()) begin
      miscompares++;
      $display("FAIL uni_ready: got %b want %b", in_ready, m_ready());
    end
    tick();
    set_in(32'h0, 2'd0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if (out_valid !== 4'b0100 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL uni_valid: valid=%b busy=%b want 0100/1",
               out_valid, busy);
    end
    vectors++;
    if (out0 !== 32'h0 || out1 !== 32'h0 || out3 !== 32'h0) begin
      miscompares++;
      $display("FAIL uni_others: %h %h %h want 0", out0, out1, out3);
    end
    set_in(32'h0, 2'd0, 1'b0, 1'b0, 4'b0100);
    e = pop_exp(2);
    vectors++;
    if (out2 !== e) begin
      miscompares++;
      $display("FAIL uni_out2: got %h want %h", out2, e);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL uni_ack: valid=%b want 0000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    set_in(32'hA, 2'd1, 1'b0, 1'b1, 4'b0000);
    tick();
    set_in(32'hB, 2'd1, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (in_ready !== 1'b0 || out1 !== last[1] || out_valid !== mval) begin
        miscompares++;
        $display("FAIL bp_hold%0d: rdy=%b out1=%h v=%b want 0/%h/%b",
                 i, in_ready, out1, out_valid, last[1], mval);
      end
      tick();
    end
    set_in(32'hB, 2'd1, 1'b0, 1'b1, 4'b0010);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ack_ready: got %b want 1", in_ready);
    end
    e = pop_exp(1);
    vectors++;
    if (out1 !== e) begin
      miscompares++;
      $display("FAIL bp_old: got %h want %h", out1, e);
    end
    tick();
    set_in(32'h0, 2'd0, 1'b0, 1'b0, 4'b0010);
    vectors++;
    if (out_valid !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_refill_valid: got %b want 0010", out_valid);
    end
    e = pop_exp(1);
    vectors++;
    if (out1 !== e) begin
      miscompares++;
      $display("FAIL bp_refill: got %h want %h", out1, e);
    end
    tick();
  endtask

  task automatic test_broadcast();
    logic [31:0] e;
    set_in(32'h5, 2'd3, 1'b0, 1'b1, 4'b0000);
    tick();
    set_in(32'hFFFF_0000, 2'd0, 1'b1, 1'b1, 4'b0000);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bc_block: ready=%b want 0", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b1000 || out0 !== last[0] || out3 !== last[3]) begin
      miscompares++;
      $display("FAIL bc_none: v=%b out0=%h out3=%h want 1000/%h/%h",
               out_valid, out0, out3, last[0], last[3]);
    end
    set_in(32'hFFFF_0000, 2'd0, 1'b1, 1'b1, 4'b1000);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bc_ack_ready: got %b want 1", in_ready);
    end
    e = pop_exp(3);
    vectors++;
    if (out3 !== e) begin
      miscompares++;
      $display("FAIL bc_old3: got %h want %h", out3, e);
    end
    tick();
    set_in(32'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
    vectors++;
    if (out_valid !== 4'b1111) begin
      miscompares++;
      $display("FAIL bc_valid: got %b want 1111", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      e = pop_exp(k);
      vectors++;
      if (outk(k) !== e) begin
        miscompares++;
        $display("FAIL bc_out%0d: got %h want %h", k, outk(k), e);
      end
    end
    tick();
  endtask

  task automatic test_sweep();
    logic [31:0] e;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_in(i, i[1:0], 1'b0, 1'b1, 4'b1111);
      else set_in(32'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
      if (i < 4) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL sweep_ready%0d: got %b want 1", i, in_ready);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (mval[k]) begin
          e = pop_exp(k);
          vectors++;
          if (outk(k) !== e || out_valid[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_out%0d: got %h v=%b want %h v=1",
                     k, outk(k), out_valid[k], e);
          end
        end
      end
      tick();
    end
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL sweep_drain: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_spurious_reset();
    set_in(32'h0, 2'd0, 1'b0, 1'b0, 4'b1111);
    tick();
    set_in(32'h0, 2'd0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if (out_valid !== 4'b0000 || out0 !== last[0] || out1 !== last[1] ||
        out2 !== last[2] || out3 !== last[3]) begin
      miscompares++;
      $display("FAIL spurious: v=%b %h %h %h %h want 0000 %h %h %h %h",
               out_valid, out0, out1, out2, out3,
               last[0], last[1], last[2], last[3]);
    end
    set_in(32'h11, 2'd0, 1'b0, 1'b1, 4'b0000);
    tick();
    set_in(32'h22, 2'd2, 1'b0, 1'b1, 4'b0000);
    tick();
    set_in(32'h33, 2'd1, 1'b0, 1'b1, 4'b0000);
    vectors++;
    if (out_valid !== 4'b0101 || out0 !== 32'h11 || out2 !== 32'h22) begin
      miscompares++;
      $display("FAIL fill: v=%b out0=%h out2=%h want 0101/11/22",
               out_valid, out0, out2);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'b0000 || out0 !== 32'h0 || out2 !== 32'h0 ||
        busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst: v=%b out0=%h out2=%h busy=%b want 0",
               out_valid, out0, out2, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 4'b0000 || out1 !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_inflight: v=%b out1=%h want 0000/0",
               out_valid, out1);
    end
    @(negedge clk);
    clear_model();
    reset_n = 1'b1;
    set_in(32'h44, 2'd3, 1'b0, 1'b1, 4'b0000);
    tick();
    set_in(32'h0, 2'd0, 1'b0, 1'b0, 4'b0000);
    vectors++;
    if (out_valid !== 4'b1000 || out3 !== last[3]) begin
      miscompares++;
      $display("FAIL post_rst: v=%b out3=%h want 1000/%h",
               out_valid, out3, last[3]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    in_data     = 32'h0;
    in_sel      = 2'd0;
    in_bcast    = 1'b0;
    in_valid    = 1'b0;
    out_ack     = 4'b0000;
    mval        = 4'b0000;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_sweep();
    test_spurious_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
